key_priority_encoder: RTL and testbench
=======================================

Name: key_priority_encoder

Overview:
- Converts four active-low key/select lines back into a 2-bit index.
- Encoding matches the team's 2-to-4 active-low decoder: index 0 corresponds to 1110 and index 3 to 0111.
- Front-end block: synchronises the raw asynchronous board inputs, debounces them as a vector, priority-encodes the debounced vector, and emits one-cycle press/release strobes.
- Output feeds control logic that consumes a 2-bit code plus a valid strobe.

Parameters:
- DEBOUNCE_CYCLES, 50000: clock cycles the synchronised vector must hold unchanged before it is accepted (1 ms at 50 MHz). Legal range 2..65535.
- CNT_W, 16: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk, input, 1: single system clock; all logic on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- keys_n, input, 4: raw active-low lines, asynchronous to clk. Bit k low means key k is pressed.
- code, output, 2: index of the lowest-numbered pressed key in the debounced vector. Registered.
- valid, output, 1: one-cycle strobe; code/multi updated for a new pressed pattern.
- released, output, 1: one-cycle strobe; debounced vector returned to all-released (1111).
- pressed, output, 1: level; at least one key pressed in the debounced vector.
- multi, output, 1: level; more than one key pressed in the debounced vector.

Behaviour:
- Reset (async assert, sync-to-clk release handled upstream):
  - s1, s2, cand, stable = 4'b1111.
  - cnt = 0.
  - code = 0; valid, released, pressed, multi = 0.
  - Reset mid-debounce discards all pending state; no strobe is generated on reset exit.
- Synchroniser:
  - s1 <= keys_n; s2 <= s1.
  - Only s2 is used downstream.
- Debounce state machine, two states:
  - IDLE: cand == stable. If s2 != cand: cand <= s2, cnt <= 0, go to COUNT.
  - COUNT:
    - If s2 != cand: cand <= s2, cnt <= 0, stay in COUNT (chatter restarts the count).
    - Else if cnt == DEBOUNCE_CYCLES-1: stable <= cand, go to IDLE.
    - Else cnt <= cnt+1.
    - A bounce back to the old stable value still restarts the count. On completion, stable is rewritten with the same value and no strobe is generated.
- Output update occurs on the same edge that writes stable, and only if cand != stable:
  - If cand != 4'b1111:
    - valid <= 1.
    - code <= lowest k with cand[k] == 0 (1110->0, 1101->1, 1011->2, 0111->3; 1100->0, 0011->2).
    - multi <= (zero count of cand >= 2).
    - pressed <= 1.
  - If cand == 4'b1111: released <= 1, pressed <= 0, multi <= 0, and code holds its last value.
  - valid and released are never high together. Both self-clear on the next edge.
- Latency: if keys_n changes before edge E and then holds, the strobe is high in the cycle following edge E+DEBOUNCE_CYCLES+2.
- Pattern-to-pattern change (e.g. 1110 -> 1100 with no release in between):
  - New valid with the recomputed code/multi.
  - No released strobe.
- cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset check: hold rst_n=0 with keys_n=0000 -> all outputs 0. Release rst_n with keys_n at 1111 -> no strobe for 20 cycles.
- Single press and release:
  - keys_n 1111->1011 held -> valid pulses exactly once, 7 cycles after the change edge, with code=2, multi=0, pressed=1.
  - Return to 1111 -> released pulses once, 7 cycles later; pressed=0; code stays 2.
- Chatter: toggle keys_n 1111/1101 every 2 cycles for 20 cycles, then hold 1101 -> no strobe during toggling; a single valid with code=1 after the hold.
- Priority and multi:
  - 1111->0110 -> valid, code=0, multi=1.
  - Then 0110->0111 -> valid, code=3, multi=0; no released strobe.
- Glitch back to the stable value: from a stable 1110, pulse keys_n to 1111 for 2 cycles -> no valid, no released; outputs unchanged.
- Reset mid-operation:
  - Assert rst_n=0 two cycles after keys_n goes 1111->1101 -> outputs clear at once.
  - After release with 1101 still held -> valid with code=1 arrives 7 cycles after the first edge.

Source files
------------

// File: rtl/key_priority_encoder.sv
// Front end for four active-low key lines: two-flop synchroniser, vector debounce,
// lowest-index priority encode, and one-cycle press/release strobes.
module key_priority_encoder #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] keys_n,
    output logic [1:0] code,
    output logic       valid,
    output logic       released,
    output logic       pressed,
    output logic       multi
);

    localparam logic [0:0]       IDLE    = 1'b0;
    localparam logic [0:0]       COUNT   = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [0:0]       state;
    logic [3:0]       s1, s2;
    logic [3:0]       cand, stable;
    logic [CNT_W-1:0] cnt;

    logic [1:0] cand_code;
    logic [3:0] cand_zeros;
    logic       cand_multi;

    // Lowest pressed key wins; more than one zero means a chord.
    always_comb begin
        cand_code  = 2'd3;
        cand_zeros = ~cand;
        cand_multi = (cand_zeros & (cand_zeros - 4'd1)) != 4'd0;
        casez (cand)
            4'b???0: cand_code = 2'd0;
            4'b??01: cand_code = 2'd1;
            4'b?011: cand_code = 2'd2;
            default: cand_code = 2'd3;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s1       <= 4'b1111;
            s2       <= 4'b1111;
            cand     <= 4'b1111;
            stable   <= 4'b1111;
            cnt      <= '0;
            code     <= 2'd0;
            valid    <= 1'b0;
            released <= 1'b0;
            pressed  <= 1'b0;
            multi    <= 1'b0;
        end else begin
            s1       <= keys_n;
            s2       <= s1;
            valid    <= 1'b0;
            released <= 1'b0;
            case (state)
                IDLE: begin
                    if (s2 != cand) begin
                        cand  <= s2;
                        cnt   <= '0;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (s2 != cand) begin
                        // Any change, even back to the old stable value, restarts the count.
                        cand <= s2;
                        cnt  <= '0;
                    end else if (cnt == CNT_MAX) begin
                        stable <= cand;
                        state  <= IDLE;
                        if (cand != stable) begin
                            if (cand != 4'b1111) begin
                                valid   <= 1'b1;
                                code    <= cand_code;
                                multi   <= cand_multi;
                                pressed <= 1'b1;
                            end else begin
                                released <= 1'b1;
                                pressed  <= 1'b0;
                                multi    <= 1'b0;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_priority_encoder.sv
// Bench for key_priority_encoder: directed scenarios plus random key traffic,
// all outputs compared every cycle against a run-length reference model.
module tb_key_priority_encoder;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] keys_n;
    logic [1:0] code;
    logic       valid, released, pressed, multi;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    int n_valid  = 0;
    int n_rel    = 0;

    key_priority_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .keys_n(keys_n), .code(code),
        .valid(valid), .released(released), .pressed(pressed), .multi(multi)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the key vector reaches the debouncer two edges late; a
    // value is accepted once it has been seen on D+1 consecutive edges after a change.
    logic [3:0] m_d1, m_d2, m_prev, m_stable;
    int         m_run;
    logic [1:0] e_code;
    logic       e_valid, e_released, e_pressed, e_multi;

    always @(posedge clk or negedge rst_n) begin
        logic [3:0] used;
        int zeros;
        int low;
        if (!rst_n) begin
            m_d1 = 4'hF; m_d2 = 4'hF; m_prev = 4'hF; m_stable = 4'hF;
            m_run = 1000;
            e_code = 0; e_valid = 0; e_released = 0; e_pressed = 0; e_multi = 0;
        end else begin
            used = m_d2;
            m_d2 = m_d1;
            m_d1 = keys_n;
            if (used != m_prev) m_run = 1;
            else if (m_run < 1000) m_run++;
            m_prev = used;
            e_valid = 0;
            e_released = 0;
            if (m_run == D + 1) begin
                if (used != m_stable) begin
                    if (used == 4'hF) begin
                        e_released = 1; e_pressed = 0; e_multi = 0;
                    end else begin
                        zeros = 0;
                        low = -1;
                        for (int k = 0; k < 4; k++) begin
                            if (!used[k]) begin
                                zeros++;
                                if (low < 0) low = k;
                            end
                        end
                        e_valid = 1; e_pressed = 1;
                        e_code = 2'(low);
                        e_multi = (zeros >= 2);
                    end
                end
                m_stable = used;
            end
        end
    end

    always @(negedge clk) begin
        if (valid) n_valid++;
        if (released) n_rel++;
        if (chk_en) begin
            check_eq("valid", 8'(valid), 8'(e_valid));
            check_eq("released", 8'(released), 8'(e_released));
            check_eq("pressed", 8'(pressed), 8'(e_pressed));
            check_eq("multi", 8'(multi), 8'(e_multi));
            check_eq("code", 8'(code), 8'(e_code));
        end
    end

    task automatic set_keys(input logic [3:0] k);
        @(negedge clk);
        #1 keys_n = k;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts negedges until the chosen strobe is seen; 99 means it never came.
    task automatic wait_strobe(input bit rel, output int cyc);
        cyc = 99;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if ((rel ? released : valid) === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int snap_v, snap_r;

        rst_n  = 1'b0;
        keys_n = 4'b0000;
        wait_cycles(3);
        check_eq("rst_code", 8'(code), 8'd0);
        check_eq("rst_valid", 8'(valid), 8'd0);
        check_eq("rst_released", 8'(released), 8'd0);
        check_eq("rst_pressed", 8'(pressed), 8'd0);
        check_eq("rst_multi", 8'(multi), 8'd0);
        chk_en = 1'b1;
        set_keys(4'b1111);
        @(negedge clk);
        #1 rst_n = 1'b1;
        snap_v = n_valid; snap_r = n_rel;
        wait_cycles(20);
        check_eq("idle_strobes", 8'(n_valid + n_rel - snap_v - snap_r), 8'd0);

        // Single press and release
        set_keys(4'b1011);
        wait_strobe(1'b0, lat);
        check_eq("press_lat", 8'(lat), 8'd7);
        check_eq("press_code", 8'(code), 8'd2);
        check_eq("press_multi", 8'(multi), 8'd0);
        check_eq("press_pressed", 8'(pressed), 8'd1);
        wait_cycles(5);
        set_keys(4'b1111);
        wait_strobe(1'b1, lat);
        check_eq("rel_lat", 8'(lat), 8'd7);
        check_eq("rel_pressed", 8'(pressed), 8'd0);
        check_eq("rel_code", 8'(code), 8'd2);
        wait_cycles(5);

        // Chatter
        snap_v = n_valid; snap_r = n_rel;
        for (int i = 0; i < 10; i++) begin
            set_keys((i % 2 == 0) ? 4'b1101 : 4'b1111);
            wait_cycles(1);
        end
        check_eq("chatter_strobes", 8'(n_valid + n_rel - snap_v - snap_r), 8'd0);
        set_keys(4'b1101);
        wait_strobe(1'b0, lat);
        check_eq("chatter_lat", 8'(lat), 8'd7);
        check_eq("chatter_code", 8'(code), 8'd1);
        wait_cycles(4);
        set_keys(4'b1111);
        wait_strobe(1'b1, lat);
        wait_cycles(4);

        // Priority, multi, pattern-to-pattern change
        set_keys(4'b0110);
        wait_strobe(1'b0, lat);
        check_eq("multi_code", 8'(code), 8'd0);
        check_eq("multi_multi", 8'(multi), 8'd1);
        wait_cycles(4);
        snap_r = n_rel;
        set_keys(4'b0111);
        wait_strobe(1'b0, lat);
        check_eq("p2p_code", 8'(code), 8'd3);
        check_eq("p2p_multi", 8'(multi), 8'd0);
        check_eq("p2p_no_rel", 8'(n_rel - snap_r), 8'd0);
        wait_cycles(4);

        // Glitch back to the stable value
        set_keys(4'b1110);
        wait_strobe(1'b0, lat);
        wait_cycles(4);
        snap_v = n_valid; snap_r = n_rel;
        set_keys(4'b1111);
        wait_cycles(1);
        set_keys(4'b1110);
        wait_cycles(15);
        check_eq("glitch_strobes", 8'(n_valid + n_rel - snap_v - snap_r), 8'd0);
        check_eq("glitch_code", 8'(code), 8'd0);
        check_eq("glitch_pressed", 8'(pressed), 8'd1);
        set_keys(4'b1111);
        wait_strobe(1'b1, lat);
        wait_cycles(4);

        // Reset mid-debounce
        set_keys(4'b1101);
        wait_cycles(2);
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_pressed", 8'(pressed), 8'd0);
        check_eq("midrst_code", 8'(code), 8'd0);
        wait_cycles(2);
        @(negedge clk);
        #1 rst_n = 1'b1;
        wait_strobe(1'b0, lat);
        check_eq("midrst_lat", 8'(lat), 8'd7);
        check_eq("midrst_code2", 8'(code), 8'd1);
        wait_cycles(4);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            set_keys(4'($urandom_range(0, 15)));
            wait_cycles($urandom_range(0, 8));
        end
        set_keys(4'b1111);
        wait_cycles(15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
